// File: rtl/lzc_word_feeder_if.sv
// lzc_word_feeder_if: operand handshake from upstream plus the start/word stream toward the LZC
interface lzc_word_feeder_if #(
    parameter int width = 4,
    parameter int word = 8
);
    logic in_valid;
    logic in_ready;
    logic [width*word-1:0] in_data;
    logic hold;
    logic mode;
    logic ivalid;
    logic [width-1:0] data;
    logic busy;
    modport master (output in_valid, in_data, hold, input in_ready, mode, ivalid, data, busy);
    modport slave (input in_valid, in_data, hold, output in_ready, mode, ivalid, data, busy);
endinterface

// File: rtl/lzc_word_feeder.sv
// lzc_word_feeder: double-buffers operands and streams each one MSB-word-first to the LZC
// after a one-cycle MODE start command.
module lzc_word_feeder #(
    parameter int width = 4,
    parameter int word = 8
) (
    input logic clk,
    input logic rst_n,
    lzc_word_feeder_if.slave bus
);
    localparam int n = width * word;
    localparam int cw = $clog2(word + 1);
    typedef enum logic [1:0] {IDLE, START, STREAM} state_t;
    state_t state;
    logic [n-1:0] act, pend;
    logic [cw-1:0] cnt;
    logic pend_v, done, take, hs;
    assign done = cnt == cw'(word);
    // PEND empties into ACTIVE on the same edge it may be refilled
    assign take = pend_v && (state == IDLE || (state == STREAM && done));
    assign bus.in_ready = !pend_v || take;
    assign hs = bus.in_valid && bus.in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            act <= '0;
            pend <= '0;
            pend_v <= 1'b0;
            cnt <= '0;
            bus.mode <= 1'b0;
            bus.ivalid <= 1'b0;
            bus.data <= '0;
            bus.busy <= 1'b0;
        end else begin
            if (hs) begin
                pend <= bus.in_data;
                pend_v <= 1'b1;
            end else if (take) begin
                pend_v <= 1'b0;
            end
            bus.mode <= 1'b0;
            bus.ivalid <= 1'b0;
            bus.data <= '0;
            if (take) begin
                act <= pend;
                cnt <= '0;
                bus.mode <= 1'b1;
                bus.busy <= 1'b1;
                state <= START;
            end else if (state == STREAM && done) begin
                bus.busy <= 1'b0;
                state <= IDLE;
            end else if (state != IDLE) begin
                // START always advances; HOLD only gates the word itself
                state <= STREAM;
                if (!bus.hold) begin
                    bus.ivalid <= 1'b1;
                    bus.data <= act[n-1 -: width];
                    act <= act << width;
                    cnt <= cnt + cw'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_lzc_word_feeder.sv
// tb_lzc_word_feeder: table vectors, hand-written corner sequences and random traffic
// checked against a queue-based reference model of the feeder.
module tb_lzc_word_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lzc_word_feeder_if #(.width(4), .word(8)) f();
    lzc_word_feeder_if #(.width(4), .word(1)) g();
    lzc_word_feeder #(.width(4), .word(8)) dut (.clk(clk), .rst_n(rst_n), .bus(f));
    lzc_word_feeder #(.width(4), .word(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(g));

    typedef struct {
        logic [31:0] op;
        int hs;
        int hl;
        logic [47:0] d;
        logic [11:0] v;
    } vec_t;
    vec_t tbl[5];

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] m_words[$];
    logic [31:0] m_pend[$];
    int m_rem = 0;
    logic e_mode = 1'b0, e_iv = 1'b0, e_busy = 1'b0;
    logic [3:0] e_data = 4'h0;
    logic prev_iv = 1'b0, cur_iv = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_pend.delete();
        m_rem = 0;
        e_mode = 1'b0;
        e_iv = 1'b0;
        e_data = 4'h0;
        e_busy = 1'b0;
    endtask

    // one operand in flight plus at most one waiting; a new one starts only when the active is spent
    task automatic model_step();
        logic rdy;
        logic [31:0] op;
        rdy = m_pend.size() == 0 || m_rem == 0;
        e_mode = 1'b0;
        e_iv = 1'b0;
        e_data = 4'h0;
        if (m_pend.size() != 0 && m_rem == 0) begin
            op = m_pend.pop_front();
            for (int i = 0; i < 8; i++) m_words.push_back(op[31-4*i -: 4]);
            m_rem = 8;
            e_mode = 1'b1;
            e_busy = 1'b1;
        end else if (m_rem > 0) begin
            if (!f.hold) begin
                e_iv = 1'b1;
                e_data = m_words.pop_front();
                m_rem--;
            end
        end else begin
            e_busy = 1'b0;
        end
        if (f.in_valid && rdy) m_pend.push_back(f.in_data);
    endtask

    task automatic edge_();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        prev_iv = cur_iv;
        cur_iv = f.ivalid;
        chk("mode", f.mode, e_mode);
        chk("ivalid", f.ivalid, e_iv);
        chk("data", f.data, e_data);
        chk("busy", f.busy, e_busy);
        chk("in_ready", f.in_ready, m_pend.size() == 0 || m_rem == 0);
    endtask

    task automatic send(input logic [31:0] op, output int st);
        logic ok;
        ok = 1'b0;
        st = 0;
        f.in_valid = 1'b1;
        f.in_data = op;
        for (int i = 0; i < 64; i++) begin
            ok = f.in_ready;
            edge_();
            if (ok) break;
            st++;
            tick();
        end
        f.in_valid = 1'b0;
        chk("accept_timeout", ok, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            edge_();
            tick();
            if (!f.busy) break;
        end
        chk("drain_timeout", f.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, cnt;
        logic rdy_q;
        logic [4:0] w1_mode, w1_iv, w1_busy;
        logic [19:0] w1_d;
        f.in_valid = 1'b0; f.in_data = '0; f.hold = 1'b0;
        g.in_valid = 1'b0; g.in_data = '0; g.hold = 1'b0;
        tbl[0] = '{32'h0B5D_0001, 0, 0, 48'h0B5D_0001_0000, 12'hFF0};
        tbl[1] = '{32'h1234_5678, 3, 3, 48'h1230_0045_6780, 12'hE3E};
        tbl[2] = '{32'hA5C3_E1F0, 0, 2, 48'h00A5_C3E1_F000, 12'h3FC};
        tbl[3] = '{32'h8765_4321, 7, 1, 48'h8765_4320_1000, 12'hFE8};
        tbl[4] = '{32'hFFFF_FFFF, 0, 0, 48'hFFFF_FFFF_0000, 12'hFF0};
        edge_();
        tick();
        chk("rst_mode", f.mode, 0);
        chk("rst_ivalid", f.ivalid, 0);
        chk("rst_data", f.data, 0);
        chk("rst_busy", f.busy, 0);
        chk("rst_ready", f.in_ready, 1);
        edge_();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            send(tbl[k].op, st);
            tick();
            edge_();
            tick();
            chk("tbl_mode", f.mode, 1);
            chk("tbl_start_iv", f.ivalid, 0);
            chk("tbl_start_busy", f.busy, 1);
            for (int s = 0; s < 8 + tbl[k].hl; s++) begin
                f.hold = s >= tbl[k].hs && s < tbl[k].hs + tbl[k].hl;
                edge_();
                tick();
                chk("tbl_iv", f.ivalid, tbl[k].v[11-s]);
                chk("tbl_data", f.data, tbl[k].d[47-4*s -: 4]);
                chk("tbl_mode_low", f.mode, 0);
                chk("tbl_busy", f.busy, 1);
            end
            f.hold = 1'b0;
            edge_();
            tick();
            chk("tbl_end_busy", f.busy, 0);
            chk("tbl_end_ready", f.in_ready, 1);
        end

        send(32'h0B5D_0001, st);
        tick();
        repeat (3) begin edge_(); tick(); end
        send(32'hFFFF_FFFF, st);
        chk("b2b_second_stalls", st, 0);
        tick();
        send(32'h1357_9BDF, st);
        chk("b2b_third_stalled", st > 0, 1);
        tick();
        chk("b2b_gap_mode", f.mode, 1);
        chk("b2b_gap_prev_word", prev_iv, 1);
        edge_();
        tick();
        chk("b2b_resume_iv", f.ivalid, 1);
        chk("b2b_resume_data", f.data, 4'hF);
        drain();

        send(32'h1234_5678, st);
        tick();
        send(32'h0B5D_0001, st);
        tick();
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 5; i++) begin
            edge_();
            tick();
            if (f.ivalid) cnt++;
        end
        chk("rst_words_seen", cnt, 5);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_mode", f.mode, 0);
        chk("arst_ivalid", f.ivalid, 0);
        chk("arst_data", f.data, 0);
        chk("arst_busy", f.busy, 0);
        chk("arst_ready", f.in_ready, 1);
        edge_();
        tick();
        edge_();
        rst_n = 1'b1;
        tick();
        repeat (4) begin
            edge_();
            tick();
            chk("no_residual_iv", f.ivalid, 0);
        end
        send(32'h9ABC_DEF0, st);
        tick();
        edge_();
        tick();
        chk("post_rst_mode", f.mode, 1);
        edge_();
        tick();
        chk("post_rst_word0", f.data, 4'h9);
        drain();

        w1_mode = 5'b10100;
        w1_iv = 5'b01010;
        w1_busy = 5'b11110;
        w1_d = 20'h00090;
        g.in_valid = 1'b1;
        g.in_data = 4'h0;
        chk("w1_ready", g.in_ready, 1);
        edge_();
        g.in_data = 4'h9;
        tick();
        chk("w1_ready_xfer", g.in_ready, 1);
        edge_();
        g.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("w1_mode", g.mode, w1_mode[4-k]);
            chk("w1_ivalid", g.ivalid, w1_iv[4-k]);
            chk("w1_data", g.data, w1_d[19-4*k -: 4]);
            chk("w1_busy", g.busy, w1_busy[4-k]);
            edge_();
        end
        tick();

        rdy_q = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (!(f.in_valid && !rdy_q)) begin
                f.in_valid = ($urandom % 3) == 0;
                f.in_data = $urandom;
            end
            f.hold = ($urandom % 4) == 0;
            rdy_q = f.in_ready;
            edge_();
            tick();
        end
        f.in_valid = 1'b0;
        f.hold = 1'b0;
        repeat (2) begin edge_(); tick(); end
        drain();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lzc_word_feeder.md
Name: lzc_word_feeder

Overview:
- Upstream stage of the LZC block.
- Accepts a full operand of `word` words × `width` bits through a valid/ready handshake, issues a one-cycle MODE start command, then streams the operand to the LZC MSB-word-first as one `width`-bit word per cycle on IVALID/DATA.
- Holds one pending operand in a second buffer so back-to-back operands stream without a dead cycle beyond the start command.

Parameters:
- width, 4: bits per streamed word; must be ≥1.
- word, 8: words per operand; must be ≥1. Word counter is ceil(log2(word+1)) bits.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  upstream operand valid.
- IN_READY  output  1  feeder can accept an operand this cycle. High when the pending buffer is empty. Combinational from registered state only.
- IN_DATA  input  width*word  operand; bits [width*word-1 -: width] form word 0, which is streamed first.
- HOLD  input  1  pause request; while high in STREAM, no word is issued.
- MODE  output  1  registered; one-cycle start command to the LZC, always with IVALID=0.
- IVALID  output  1  registered; DATA carries a valid word.
- DATA  output  width  registered word to the LZC; all zeros whenever IVALID=0.
- BUSY  output  1  registered; high from the MODE cycle through the last word of the final queued operand.

Behaviour:
- Reset (async assert, sync-style release on the next edge):
  - MODE, IVALID, BUSY = 0; DATA = 0; IN_READY = 1.
  - Both buffers empty, counter = 0, FSM = IDLE.
  - Reset mid-stream aborts the operand and discards the pending buffer; no further words are emitted.
- Buffers:
  - ACTIVE: shift register plus word counter.
  - PEND: one operand plus a valid flag.
  - Handshake fires when IN_VALID & IN_READY at an edge; IN_DATA is captured into PEND.
  - IN_DATA is ignored when IN_READY = 0. Upstream holds it stable.
- FSM (registered outputs are set on the edge that enters each state):
  - IDLE: if PEND valid, move PEND to ACTIVE, clear PEND, go to START. The operand is accepted at edge N, so MODE is high in cycle N+1.
  - START: MODE=1, IVALID=0, DATA=0, BUSY=1. Next edge goes to STREAM unconditionally; HOLD is ignored in START.
  - STREAM, HOLD=0: IVALID=1, DATA = top `width` bits of ACTIVE. Shift ACTIVE left by `width` and increment the counter.
  - STREAM, HOLD=1: IVALID=0, DATA=0. ACTIVE and counter are frozen.
  - After word `word`-1 is issued:
    - If PEND valid, the next edge transfers PEND and goes to START. Gap = 1 cycle (the MODE cycle).
    - Otherwise go to IDLE and clear BUSY at that edge.
- Simultaneous events:
  - A handshake in the same cycle that PEND transfers to ACTIVE is legal: IN_READY is high because the transfer empties PEND that edge. The new operand lands in PEND.
  - A handshake on the final-word cycle is legal.
  - HOLD on the final-word cycle delays it; HOLD is never dropped.
- Output timing:
  - MODE and IVALID are never high together.
  - IVALID count per operand is exactly `word`.
  - DATA bits are never X after reset.
- word=1 corner case: START, then one STREAM cycle, then IDLE or START.

Test Plan:
- Single operand, width=4, word=8, IN_DATA=32'h0B5D_0001, HOLD=0:
  - MODE pulse, then 8 IVALID cycles carrying 0,B,5,D,0,0,0,1.
  - BUSY high for 9 cycles, then IN_READY stays 1.
- Back-to-back: second operand 32'hFFFF_FFFF offered during the first stream.
  - Accepted immediately (IN_READY=1).
  - A third operand is stalled (IN_READY=0) until the second enters START.
  - Exactly one MODE cycle between the two word bursts.
- HOLD: assert HOLD for 3 cycles after word 2 of 32'h1234_5678.
  - IVALID=0 and DATA=0 for 3 cycles, then words 3..7 resume as 4,5,6,7,8, with no word lost or repeated.
- HOLD asserted during START: MODE still lasts exactly 1 cycle; the first word waits until HOLD drops.
- Reset mid-stream: drop RST_N after word 4 with PEND loaded.
  - Outputs go to 0 asynchronously, IN_READY=1.
  - After release, no residual words appear; a new operand streams from word 0.
- word=1, width=4: operands 4'h0 then 4'h9 back-to-back produce the sequence MODE, 0, MODE, 9 on consecutive cycles.
